// File: rtl/ws2812_frame_ctrl.sv
// rtl/ws2812_frame_ctrl.sv - WS2812 frame buffer, brightness scaling and refresh scheduler
// Double-buffered pixel store feeding a scaled flat frame to the serial LED driver.
module ws2812_frame_ctrl #(
    parameter int NUM_LED        = 8,
    parameter int ADDR_W         = 6,
    parameter int REFRESH_CYCLES = 1_000_000
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    wr_en,
    input  logic [ADDR_W-1:0]       wr_addr,
    input  logic [23:0]             wr_data,
    input  logic                    commit,
    output logic                    commit_pending,
    input  logic [7:0]              brightness,
    input  logic                    refresh_en,
    output logic                    drv_start,
    input  logic                    drv_ready,
    output logic [NUM_LED*24-1:0]   drv_frame,
    output logic                    busy,
    output logic                    frame_done,
    output logic [15:0]             frame_cnt
);

    localparam int CNT_W = $clog2(REFRESH_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_START,
        S_WAIT_BUSY,
        S_WAIT_DONE
    } state_t;

    state_t state, state_nxt;

    logic [23:0]      back  [NUM_LED];
    logic [23:0]      front [NUM_LED];
    logic [CNT_W-1:0] refresh_cnt;
    logic             refresh_due;
    logic             go;
    logic             leave_idle;
    logic             swap;
    logic             finish;

    function automatic logic [7:0] scale8(input logic [7:0] c, input logic [7:0] b);
        logic [16:0] p;
        p = {9'b0, c} * ({9'b0, b} + 17'd1);
        return p[15:8];
    endfunction

    assign go         = (commit_pending | refresh_due) & drv_ready;
    assign leave_idle = (state == S_IDLE) && go;
    assign swap       = leave_idle && commit_pending;
    assign finish     = (state == S_WAIT_DONE) && drv_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:      if (go) state_nxt = S_LOAD;
            S_LOAD:      state_nxt = S_START;
            S_START:     state_nxt = S_WAIT_BUSY;
            S_WAIT_BUSY: if (!drv_ready) state_nxt = S_WAIT_DONE;
            S_WAIT_DONE: if (drv_ready) state_nxt = S_IDLE;
            default:     state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        drv_start = (state == S_START);
        busy      = (state != S_IDLE);
    end

    // Out-of-range addresses match no slot, so they drop out naturally.
    // The swap reads back before this edge's write lands.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_LED; i++) begin
                back[i]  <= '0;
                front[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_LED; i++) begin
                if (wr_en && (wr_addr == ADDR_W'(i))) back[i] <= wr_data;
                if (swap) front[i] <= back[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            drv_frame <= '0;
        end else if (state == S_LOAD) begin
            for (int i = 0; i < NUM_LED; i++) begin
                drv_frame[24*i +: 24] <= {scale8(front[i][23:16], brightness),
                                          scale8(front[i][15:8],  brightness),
                                          scale8(front[i][7:0],   brightness)};
            end
        end
    end

    // A commit arriving in the swap cycle survives so the next frame swaps again.
    always_ff @(posedge clk) begin
        if (rst) begin
            commit_pending <= 1'b0;
        end else begin
            commit_pending <= commit | (commit_pending & ~swap);
        end
    end

    always_ff @(posedge clk) begin
        if (rst || !refresh_en) begin
            refresh_cnt <= '0;
        end else if (refresh_cnt == CNT_LAST) begin
            refresh_cnt <= '0;
        end else begin
            refresh_cnt <= refresh_cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst || !refresh_en) begin
            refresh_due <= 1'b0;
        end else if (refresh_cnt == CNT_LAST) begin
            refresh_due <= 1'b1;
        end else if (leave_idle) begin
            refresh_due <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            frame_done <= 1'b0;
            frame_cnt  <= '0;
        end else begin
            frame_done <= finish;
            if (finish) frame_cnt <= frame_cnt + 16'd1;
        end
    end

endmodule
